// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: forwarding selects, bubble control and
// default control-bundle width.
package cpu_pkg;

  localparam int CTRL_W = 12;

  // Opaque control value that EX treats as "do nothing".
  localparam int CTRL_NOP = 0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Register 0 is hardwired, so a write to it can never be a forwarding source.
  function automatic logic dest_hits(input logic       regwrite,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
    return regwrite && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX source register; EX/MEM beats MEM/WB.
module fwd_unit
  import cpu_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       exmem_regwrite,
  input  logic [4:0] exmem_rd,
  input  logic       memwb_regwrite,
  input  logic [4:0] memwb_rd,
  output logic [1:0] fwd
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_REG;
    if (dest_hits(exmem_regwrite, exmem_rd, rs)) begin
      sel = FWD_MEM;
    end else if (dest_hits(memwb_regwrite, memwb_rd, rs)) begin
      sel = FWD_WB;
    end
  end

  assign fwd = sel;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and EX operand forwarding from EX/MEM and MEM/WB.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = cpu_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              exmem_regwrite,
  input  logic              memwb_regwrite,
  input  logic [4:0]        exmem_rd,
  input  logic [4:0]        memwb_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [XLEN-1:0]   memwb_wd,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_op_a,
  output logic [XLEN-1:0]   ex_op_b,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic [XLEN-1:0] rd1_q;
  logic [XLEN-1:0] rd2_q;
  logic            luse;
  logic            rs1_hit;
  logic            rs2_hit;

  // A load in EX only blocks a consumer of its (non-zero) destination.
  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    luse    = id_valid && ex_valid && ex_memread && (ex_rd != 5'd0) &&
              (rs1_hit || rs2_hit);
    stall   = luse || ex_hold;
  end

  fwd_unit u_fwd_a (
    .rs             (ex_rs1),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .fwd            (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs             (ex_rs2),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .fwd            (fwd_b)
  );

  always_comb begin
    ex_op_a = rd1_q;
    case (fwd_a)
      FWD_MEM: ex_op_a = exmem_result;
      FWD_WB:  ex_op_a = memwb_wd;
      default: ex_op_a = rd1_q;
    endcase
  end

  always_comb begin
    ex_op_b = rd2_q;
    case (fwd_b)
      FWD_MEM: ex_op_b = exmem_result;
      FWD_WB:  ex_op_b = memwb_wd;
      default: ex_op_b = rd2_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_ctrl     <= CTRL_W'(CTRL_NOP);
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
    end else if (ex_hold) begin
      // Latch the forwarded operands: their producers leave EX/MEM and
      // MEM/WB while this instruction waits.
      rd1_q <= ex_op_a;
      rd2_q <= ex_op_b;
    end else if (flush || luse) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_ctrl     <= CTRL_W'(CTRL_NOP);
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
    end else begin
      ex_valid    <= id_valid;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      ex_ctrl     <= id_ctrl;
      ex_pc       <= id_pc;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      rd1_q       <= id_rd1;
      rd2_q       <= id_rd2;
    end
  end

  // A redirect cannot arrive while EX is stalled; hold takes priority if it does.
  a_no_flush_during_hold: assert property (
    @(posedge clk) disable iff (!rst) !(flush && ex_hold));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with an in-bench behavioural model.
module tb_id_ex_stage;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_memread;
  logic [XLEN-1:0]   id_pc, id_imm, id_rd1, id_rd2;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush, ex_hold;
  logic              exmem_regwrite, memwb_regwrite;
  logic [4:0]        exmem_rd, memwb_rd;
  logic [XLEN-1:0]   exmem_result, memwb_wd;
  logic              stall, ex_valid, ex_regwrite, ex_memread;
  logic [XLEN-1:0]   ex_pc, ex_imm, ex_op_a, ex_op_b;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [1:0]        fwd_a, fwd_b;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
    .id_rd1(id_rd1), .id_rd2(id_rd2),
    .flush(flush), .ex_hold(ex_hold),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_result(exmem_result), .memwb_wd(memwb_wd),
    .stall(stall), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              v, rw, mr;
    logic [XLEN-1:0]   pc, imm, rd1, rd2;
    logic [4:0]        rs1, rs2, rd;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t m;
  bit  checking = 0;
  int  passed = 0;
  int  total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Which stage supplies register r: 2 = EX/MEM, 1 = MEM/WB, 0 = stored value.
  function automatic logic [1:0] src_of(input logic [4:0] r);
    if (r == 0) return 2'd0;
    if (exmem_regwrite && exmem_rd == r) return 2'd2;
    if (memwb_regwrite && memwb_rd == r) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [XLEN-1:0] value_of(input logic [4:0] r, input logic [XLEN-1:0] stored);
    logic [1:0] s;
    s = src_of(r);
    if (s == 2'd2) return exmem_result;
    if (s == 2'd1) return memwb_wd;
    return stored;
  endfunction

  function automatic bit load_use();
    bit needs;
    needs = (id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd);
    return id_valid && m.v && m.mr && (m.rd != 0) && needs;
  endfunction

  task automatic model_chk();
    chk("stall",       stall,       load_use() || ex_hold);
    chk("ex_valid",    ex_valid,    m.v);
    chk("ex_regwrite", ex_regwrite, m.rw);
    chk("ex_memread",  ex_memread,  m.mr);
    chk("ex_pc",       ex_pc,       m.pc);
    chk("ex_imm",      ex_imm,      m.imm);
    chk("ex_rs1",      ex_rs1,      m.rs1);
    chk("ex_rs2",      ex_rs2,      m.rs2);
    chk("ex_rd",       ex_rd,       m.rd);
    chk("ex_ctrl",     ex_ctrl,     m.ctrl);
    chk("fwd_a",       fwd_a,       src_of(m.rs1));
    chk("fwd_b",       fwd_b,       src_of(m.rs2));
    chk("ex_op_a",     ex_op_a,     value_of(m.rs1, m.rd1));
    chk("ex_op_b",     ex_op_b,     value_of(m.rs2, m.rd2));
  endtask

  // Check current outputs, advance one clock edge in DUT and model, return at negedge.
  task automatic step();
    logic [XLEN-1:0] a, b;
    bit lu;
    #1;
    if (checking) model_chk();
    a  = value_of(m.rs1, m.rd1);
    b  = value_of(m.rs2, m.rd2);
    lu = load_use();
    @(posedge clk);
    if (!rst) m = '{default: '0};
    else if (ex_hold) begin
      m.rd1 = a;
      m.rd2 = b;
    end else if (flush || lu) m = '{default: '0};
    else m = '{v: id_valid, rw: id_regwrite, mr: id_memread, pc: id_pc, imm: id_imm,
               rd1: id_rd1, rd2: id_rd2, rs1: id_rs1, rs2: id_rs2, rd: id_rd, ctrl: id_ctrl};
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic [11:0] ctrl, input logic [31:0] r1, input logic [31:0] r2);
    id_valid = v; id_pc = pc; id_imm = pc + 32'h1000;
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; id_ctrl = ctrl;
    id_rd1 = r1; id_rd2 = r2;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m = '{default: '0};
    rst = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_wd = '0;
    set_id(1, 32'h100, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 12'h012, 32'h11, 32'h22);

    // Reset held two cycles
    step();
    checking = 1;
    #1 chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_stall", stall, 0);
    step();
    rst = 1'b1;
    step();
    #1 chk("cap_pc", ex_pc, 32'h100);
    chk("cap_valid", ex_valid, 1);

    // Load-use: lw x5 then add x7,x5,x6
    set_id(1, 32'h104, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 12'h001, 32'h0, 32'h0);
    step();
    set_id(1, 32'h108, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0, 12'h002, 32'h1111, 32'h22);
    #1 chk("luse_stall", stall, 1);
    step();
    #1 chk("bubble_valid", ex_valid, 0);
    chk("bubble_stall", stall, 0);
    exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hBAD;
    step();
    exmem_regwrite = 1'b0; exmem_rd = 5'd0;
    memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_wd = 32'hDEAD;
    #1 chk("luse_fwd_a", fwd_a, 2'b01);
    chk("luse_op_a", ex_op_a, 32'hDEAD);
    chk("luse_pc", ex_pc, 32'h108);

    // Forwarding priority on operand b
    set_id(1, 32'h10C, 5'd3, 1, 5'd7, 1, 5'd8, 1, 0, 12'h003, 32'h33, 32'h77);
    step();
    id_valid = 1'b0;
    exmem_regwrite = 1'b1; exmem_rd = 5'd7; exmem_result = 32'h1;
    memwb_regwrite = 1'b1; memwb_rd = 5'd7; memwb_wd = 32'h2;
    #1 chk("prio_fwd_b", fwd_b, 2'b10);
    chk("prio_op_b", ex_op_b, 32'h1);
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1 chk("x0_fwd_b", fwd_b, 2'b00);
    chk("x0_op_b", ex_op_b, 32'h77);
    memwb_rd = 5'd7;
    #1 chk("wb_fwd_b", fwd_b, 2'b01);
    chk("wb_op_b", ex_op_b, 32'h2);

    // Hold while operand a is forwarded from EX/MEM
    exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h55;
    memwb_regwrite = 1'b0;
    ex_hold = 1'b1;
    set_id(1, 32'h200, 5'd3, 1, 5'd7, 1, 5'd8, 1, 0, 12'h004, 32'h44, 32'h88);
    #1 chk("hold_fwd_a", fwd_a, 2'b10);
    chk("hold_stall", stall, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      #1 chk("hold_pc", ex_pc, 32'h10C);
      chk("hold_op_a", ex_op_a, 32'h55);
      chk("hold_stall_n", stall, 1);
    end
    exmem_regwrite = 1'b0;
    #1 chk("drain_op_a", ex_op_a, 32'h55);
    chk("drain_fwd_a", fwd_a, 2'b00);
    step();
    ex_hold = 1'b0;
    step();
    #1 chk("release_pc", ex_pc, 32'h200);

    // Flush
    set_id(1, 32'h300, 5'd1, 1, 5'd2, 1, 5'd4, 1, 0, 12'hABC, 32'h5, 32'h6);
    flush = 1'b1;
    #1 chk("flush_stall", stall, 0);
    step();
    flush = 1'b0;
    #1 chk("flush_valid", ex_valid, 0);
    chk("flush_regwrite", ex_regwrite, 0);
    chk("flush_ctrl", ex_ctrl, 0);

    // Load to x0 never stalls; load-use via rs2 does
    set_id(1, 32'h400, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 12'h005, 32'h1, 32'h2);
    step();
    set_id(1, 32'h404, 5'd0, 1, 5'd0, 0, 5'd9, 1, 0, 12'h006, 32'h0, 32'h0);
    #1 chk("x0_stall", stall, 0);
    step();
    set_id(1, 32'h408, 5'd1, 1, 5'd0, 0, 5'd10, 1, 1, 12'h007, 32'h9, 32'h0);
    step();
    set_id(1, 32'h40C, 5'd0, 1, 5'd10, 1, 5'd11, 1, 0, 12'h008, 32'h0, 32'h0);
    #1 chk("rs2_stall", stall, 1);
    step();
    #1 chk("rs2_bubble", ex_valid, 0);
    step();
    #1 chk("rs2_capture_pc", ex_pc, 32'h40C);

    // Reset mid-operation overrides hold
    set_id(1, 32'h500, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 12'h009, 32'h3, 32'h4);
    step();
    ex_hold = 1'b1; rst = 1'b0;
    step();
    ex_hold = 1'b0;
    #1 chk("midrst_valid", ex_valid, 0);
    chk("midrst_pc", ex_pc, 0);
    rst = 1'b1;
    step();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the pipelined CPU. Consumes the register-file read data (RD1/RD2) and decoded fields from ID, and holds them in the ID/EX pipeline register. Produces the load-use stall and inserts bubbles on stall or flush. Forwards EX/MEM and MEM/WB results so EX sees correct operands.

## Interface
Parameters:
- XLEN, 32, datapath width
- CTRL_W, 12, width of opaque decoded control bundle passed to EX

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_pc, id_imm  in  XLEN  PC and sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
- id_regwrite, id_memread  in  1  writes rd / is a load
- id_ctrl  in  CTRL_W  remaining control
- id_rd1, id_rd2  in  XLEN  register-file read data for rs1/rs2
- flush  in  1  branch redirect from EX; kill ID instruction
- ex_hold  in  1  EX cannot accept (multi-cycle unit busy)
- exmem_regwrite, memwb_regwrite  in  1  downstream write enables
- exmem_rd, memwb_rd  in  5  downstream destinations
- exmem_result, memwb_wd  in  XLEN  downstream results
- stall  out  1  hold PC and IF/ID this cycle
- ex_valid, ex_regwrite, ex_memread  out  1  registered
- ex_pc, ex_imm  out  XLEN  registered
- ex_rs1, ex_rs2, ex_rd  out  5  registered
- ex_ctrl  out  CTRL_W  registered
- ex_op_a, ex_op_b  out  XLEN  forwarded operands (combinational from registered state)
- fwd_a, fwd_b  out  2  forward select: 00 register, 01 MEM/WB, 10 EX/MEM

## Operation
- Load-use: luse = id_valid & ex_valid & ex_memread & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- stall = luse | ex_hold (combinational).
- Register update, priority order:
  1. rst low: all registered outputs 0 (valid, regwrite, memread, ctrl, pc, imm, indices, operands).
  2. ex_hold: contents retained, except stored rd1/rd2 are overwritten with ex_op_a/ex_op_b. This preserves forwarded values while EX/MEM and MEM/WB drain.
  3. flush: bubble, i.e. valid, regwrite, memread, ctrl ← 0. Other fields don't care; implementation zeros them.
  4. luse: bubble, as for flush.
  5. else capture all id_* fields.
- flush together with ex_hold is illegal. Hold wins, and a simulation assertion fires.
- Forwarding, per operand (a shown):
  - fwd_a = 10 if exmem_regwrite & exmem_rd≠0 & exmem_rd==ex_rs1;
  - else 01 if memwb_regwrite & memwb_rd≠0 & memwb_rd==ex_rs1;
  - else 00.
  - EX/MEM has priority. Index 0 never forwards.
- No ID-side write-back bypass. The register file writes on the falling edge, so id_rd1/id_rd2 already include the WB write of the same cycle.
- Forwarding is evaluated even when ex_valid=0. Consumers qualify with ex_valid.

## Timing
- Capture latency 1 cycle: id_* at edge N appear on ex_* after edge N.
- stall, ex_op_*, fwd_* are same-cycle combinational. No combinational path from stall back to id_*.
- Load-use costs exactly one bubble. On the next cycle the load is in MEM, luse=0, and the consumer captures. EX then forwards from MEM/WB (fwd=01).
- Reset mid-operation: the next edge with rst low clears everything regardless of flush/hold/luse.

## Structure
- Shared package cpu_pkg: CTRL_W default, fwd encodings (FWD_REG=00, FWD_WB=01, FWD_MEM=10), bubble control constant CTRL_NOP=0.
- One sub-module: fwd_unit (pure combinational, instantiated once per operand). Inputs: rs, exmem/memwb regwrite+rd. Output: 2-bit select.
- Hazard detection and the pipeline register live in id_ex_stage.

## Test plan
- Reset: hold rst=0 two cycles with id_valid=1 → all ex_* 0, stall=0. Release → next edge captures id_pc=0x100.
- Load-use: EX holds lw x5 (ex_memread=1, ex_rd=5); ID add rs1=5 uses_rs1=1 → stall=1, next edge ex_valid=0. Following edge captures add; with memwb_rd=5, memwb_wd=0xDEAD → fwd_a=01, ex_op_a=0xDEAD.
- Priority: exmem_rd=memwb_rd=ex_rs2=7, both regwrite, exmem_result=1, memwb_wd=2 → fwd_b=10, ex_op_b=1. Same with rd=0 → fwd_b=00, op_b=stored rd2.
- Flush: flush=1 with id_valid=1 → next cycle ex_valid=0, ex_regwrite=0, ex_ctrl=0. stall unaffected by flush.
- Hold: ex_hold=1 for 3 cycles while fwd_a=10 with exmem_result=0x55, then exmem_regwrite drops → ex_op_a stays 0x55, ex_pc unchanged, stall=1 throughout.
- x0 guard: lw x0 in EX, ID uses rs1=0 → stall=0.
